// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the MIPS multicycle datapath with memory wait states
// Optional feature macro: MCTRL_JUMP_EN (adds the JUMP state for opcode 000010).
module multicycle_control #(
  parameter int MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] alu_control,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  // Wait counter width is derived from MEM_WAIT and never overridden.
  localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t           cur;
  logic [CNT_W-1:0] cnt;
  logic             store_op;   // remembers lw vs sw from DECODE for the MEMADR branch
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_MAX);

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: return 1'b1;
`ifdef MCTRL_JUMP_EN
      OP_J: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_funct(input logic [5:0] fn);
    case (fn)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // State register, memory wait counter and store/load flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      cnt      <= '0;
      store_op <= 1'b0;
    end else begin
      case (cur)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (cnt_done) begin
            cnt <= '0;
            case (cur)
              S_FETCH: cur <= S_DECODE;
              S_MEMRD: cur <= S_MEMWB;
              default: cur <= S_FETCH;
            endcase
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          store_op <= (opcode == OP_SW);
          case (opcode)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_RTYPE:     cur <= S_EXEC;
            OP_BEQ:       cur <= S_BRANCH;
            OP_ADDI:      cur <= S_ADDIEXEC;
`ifdef MCTRL_JUMP_EN
            OP_J:         cur <= S_JUMP;
`endif
            default:      cur <= S_FETCH;
          endcase
        end
        S_MEMADR:   cur <= store_op ? S_MEMWR : S_MEMRD;
        S_EXEC:     cur <= S_ALUWB;
        S_ADDIEXEC: cur <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB: cur <= S_FETCH;
        default: begin
          cur <= S_FETCH;
          cnt <= '0;
        end
      endcase
    end
  end

  // Moore control outputs decoded from the current state and wait counter.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = cnt_done;
        pc_write  = cnt_done;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !is_legal_op(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        illegal_op = !is_legal_funct(funct);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
`ifdef MCTRL_JUMP_EN
      S_JUMP: pc_write = 1'b1;
`endif
      default: ;
    endcase
  end

  // ALU control: fixed add/sub for address and branch work, funct decode for R-type.
  always_comb begin
    alu_control = 4'b0010;
    case (alu_op)
      2'b01: alu_control = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100010: alu_control = 4'b0110;
          6'b100100: alu_control = 4'b0000;
          6'b100101: alu_control = 4'b0001;
          6'b101010: alu_control = 4'b0111;
          default:   alu_control = 4'b0010;
        endcase
      end
      default: alu_control = 4'b0010;
    endcase
  end

`ifdef MCTRL_JUMP_EN
  assign pc_source = {cur == S_JUMP, cur == S_BRANCH};
`else
  assign pc_source = {1'b0, cur == S_BRANCH};
`endif

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control (MEM_WAIT 0 and 3 instances)
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_en;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    int st;
    bit last;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cyc0;
    int         cyc3;
  } cyc_vec_t;

  typedef struct {
    logic [5:0] fn;
    logic [3:0] ctl;
    logic       ill;
  } alu_vec_t;

  logic       clk = 1'b0;
  logic       rst_n_v  [2];
  logic [5:0] opcode_v [2];
  logic [5:0] funct_v  [2];
  logic       zero_v   [2];
  outs_t      act      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic       pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] alu_control, state;

    multicycle_control #(.MEM_WAIT((k == 0) ? 0 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n_v[k]), .opcode(opcode_v[k]), .funct(funct_v[k]), .zero(zero_v[k]),
      .pc_en(pc_en), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .alu_control(alu_control), .pc_source(pc_source),
      .illegal_op(illegal_op), .state(state)
    );

    assign act[k] = {pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     alu_control, pc_source, illegal_op, state};
  end

  // ---------------- reference model ----------------
  step_t seq[$];

  function automatic int mem_wait(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    if (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 || op == 6'b001000)
      return 1'b1;
`ifdef MCTRL_JUMP_EN
    if (op == 6'b000010) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn);
    if (aop == 2'b01) return 4'd6;
    if (aop != 2'b10) return 4'd2;
    if (fn == 6'h22) return 4'd6;
    if (fn == 6'h24) return 4'd0;
    if (fn == 6'h25) return 4'd1;
    if (fn == 6'h2a) return 4'd7;
    return 4'd2;
  endfunction

  function automatic bit fn_known(input logic [5:0] fn);
    return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a);
  endfunction

  function automatic outs_t model_out(input int st, input bit last, input logic z,
                                      input logic [5:0] op, input logic [5:0] fn);
    outs_t o;
    o = '0;
    o.state = st[3:0];
    case (st)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = last; o.pc_write = last; end
      1:  begin o.alu_src_b = 2'b11; o.illegal_op = !op_known(op); end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; o.illegal_op = !fn_known(fn); end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
      9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      10: o.reg_write = 1;
      11: begin o.pc_write = 1; o.pc_source = 2'b10; end
      default: ;
    endcase
    o.alu_control = ref_alu(o.alu_op, fn);
    o.pc_en = o.pc_write | (o.pc_write_cond & z);
    return o;
  endfunction

  // Whole-instruction state walk built from the instruction class.
  task automatic build_seq(input int k, input logic [5:0] op);
    int w;
    w = mem_wait(k);
    seq.delete();
    for (int i = 0; i <= w; i++) seq.push_back('{0, i == w});
    seq.push_back('{1, 1'b0});
    if (op == 6'b100011) begin
      seq.push_back('{2, 1'b0});
      for (int i = 0; i <= w; i++) seq.push_back('{3, 1'b0});
      seq.push_back('{4, 1'b0});
    end else if (op == 6'b101011) begin
      seq.push_back('{2, 1'b0});
      for (int i = 0; i <= w; i++) seq.push_back('{5, 1'b0});
    end else if (op == 6'b000000) begin
      seq.push_back('{6, 1'b0});
      seq.push_back('{7, 1'b0});
    end else if (op == 6'b000100) begin
      seq.push_back('{8, 1'b0});
    end else if (op == 6'b001000) begin
      seq.push_back('{9, 1'b0});
      seq.push_back('{10, 1'b0});
    end else if (op_known(op)) begin
      seq.push_back('{11, 1'b0});
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_outs(input string name, input int k, input int step, input outs_t exp);
    checks++;
    if (act[k] !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d step=%0d got=%h exp=%h", name, k, step, act[k], exp);
    end
  endtask

  task automatic check_val(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h", name, k, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode_v[k] = op;
    funct_v[k]  = fn;
    zero_v[k]   = z;
    build_seq(k, op);
    foreach (seq[i]) begin
      #1;
      check_outs("model", k, i, model_out(seq[i].st, seq[i].last, z, op, fn));
      step_clk();
    end
  endtask

  task automatic measure(input int k, input logic [5:0] op, input logic [5:0] fn, input logic z,
                         output int cyc);
    bit seen;
    opcode_v[k] = op;
    funct_v[k]  = fn;
    zero_v[k]   = z;
    seen = 0;
    cyc  = 0;
    while (cyc < 64) begin
      step_clk();
      cyc++;
      if (act[k].state != 4'd0) seen = 1;
      else if (seen) break;
    end
    if (cyc >= 64) begin
      errors++;
      $display("FAIL timeout inst=%0d op=%b", k, op);
    end
  endtask

  // ---------------- stimulus ----------------
  cyc_vec_t cyc_tab[$];
  alu_vec_t alu_tab[$];
  logic [5:0] rand_ops [7];

  initial begin
    int cyc;
    int jc0, jc3;
`ifdef MCTRL_JUMP_EN
    jc0 = 3; jc3 = 6;
`else
    jc0 = 2; jc3 = 5;
`endif
    cyc_tab.push_back('{6'b100011, 6'h20, 1'b0, 5, 11});
    cyc_tab.push_back('{6'b101011, 6'h20, 1'b0, 4, 10});
    cyc_tab.push_back('{6'b000000, 6'h2a, 1'b0, 4, 7});
    cyc_tab.push_back('{6'b000100, 6'h20, 1'b1, 3, 6});
    cyc_tab.push_back('{6'b001000, 6'h20, 1'b0, 4, 7});
    cyc_tab.push_back('{6'b000010, 6'h20, 1'b0, jc0, jc3});
    cyc_tab.push_back('{6'b111111, 6'h20, 1'b0, 2, 5});

    alu_tab.push_back('{6'h20, 4'b0010, 1'b0});
    alu_tab.push_back('{6'h22, 4'b0110, 1'b0});
    alu_tab.push_back('{6'h24, 4'b0000, 1'b0});
    alu_tab.push_back('{6'h25, 4'b0001, 1'b0});
    alu_tab.push_back('{6'h2a, 4'b0111, 1'b0});
    alu_tab.push_back('{6'h3f, 4'b0010, 1'b1});
    alu_tab.push_back('{6'h00, 4'b0010, 1'b1});

    rand_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b110011};

    for (int k = 0; k < 2; k++) begin
      rst_n_v[k]  = 1'b0;
      opcode_v[k] = 6'd0;
      funct_v[k]  = 6'd0;
      zero_v[k]   = 1'b0;
    end
    repeat (2) step_clk();

    // Reset state of both configurations.
    for (int k = 0; k < 2; k++)
      check_outs("reset", k, 0, model_out(0, mem_wait(k) == 0, 1'b0, 6'd0, 6'd0));

    for (int k = 0; k < 2; k++) begin
      rst_n_v[k] = 1'b1;

      // Instruction lengths per opcode class.
      foreach (cyc_tab[i]) begin
        measure(k, cyc_tab[i].op, cyc_tab[i].fn, cyc_tab[i].z, cyc);
        check_val("cycles", k, cyc, (k == 0) ? cyc_tab[i].cyc0 : cyc_tab[i].cyc3);
      end

      // R-type ALU decode and illegal funct pulse, write-back still happens.
      foreach (alu_tab[i]) begin
        opcode_v[k] = 6'b000000;
        funct_v[k]  = alu_tab[i].fn;
        repeat (mem_wait(k) + 2) step_clk();
        check_val("exec_state", k, act[k].state, 4'd6);
        check_val("alu_control", k, act[k].alu_control, alu_tab[i].ctl);
        check_val("exec_illegal", k, act[k].illegal_op, alu_tab[i].ill);
        step_clk();
        check_val("aluwb_write", k, {act[k].state, act[k].reg_write, act[k].reg_dst, act[k].illegal_op},
                  {4'd7, 3'b110});
        step_clk();
      end

      // Branch taken / not taken.
      for (int z = 1; z >= 0; z--) begin
        opcode_v[k] = 6'b000100;
        zero_v[k]   = z[0];
        repeat (mem_wait(k) + 2) step_clk();
        check_val("branch_pc_en", k, {act[k].state, act[k].pc_en}, {4'd8, z[0]});
        step_clk();
      end

      // Randomized instruction stream against the model.
      for (int n = 0; n < 120; n++) begin
        logic [5:0] fn;
        fn = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                         : ((n % 2 == 0) ? 6'h2a : 6'h22);
        run_instr(k, rand_ops[$urandom_range(0, 6)], fn, 1'($urandom_range(0, 1)));
      end

      if (k == 0) rst_n_v[0] = 1'b0;
    end

    // sw on MEM_WAIT=3: reset falls during the second MEMWR cycle.
    opcode_v[1] = 6'b101011;
    repeat (7) step_clk();
    check_val("memwr2", 1, {act[1].state, act[1].mem_write}, {4'd5, 1'b1});
    #2;
    rst_n_v[1] = 1'b0;
    #1;
    check_outs("async_reset", 1, 0, model_out(0, 1'b0, zero_v[1], 6'b101011, funct_v[1]));
    step_clk();
    check_outs("reset_hold", 1, 0, model_out(0, 1'b0, zero_v[1], 6'b101011, funct_v[1]));
    rst_n_v[1] = 1'b1;
    run_instr(1, 6'b100011, 6'h20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
